// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage ALU.
// Holds the opcode encodings, the flag-mask bit positions, the FSM state type
// and a helper that merges newly computed flags into the held flag state.
package ex_pkg;

    // 4-bit opcode encodings; 9..15 are reserved.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    // Bit positions inside the {ov, neg, zero, carry} flag vector and mask.
    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_OV    = 3;

    // FSM state encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

    // Bits with mask=1 take the new value, the rest keep the old one.
    function automatic logic [3:0] merge_flags(input logic [3:0] old_f,
                                               input logic [3:0] new_f,
                                               input logic [3:0] mask);
        return (new_f & mask) | (old_f & ~mask);
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative unsigned shift-add multiplier.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start_i    - load operands and clear the accumulator/counter
//   en_i       - perform one iteration this cycle
//   a_i, b_i   - multiplicand and multiplier (captured on start_i)
//   done_o     - high during the final (WIDTH-th) iteration cycle
//   product_o  - full 2*WIDTH product, valid while done_o is high
module ex_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               en_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [SH_W-1:0]    cnt_q;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = en_i && (cnt_q == CNT_LAST);
    // The last partial product is folded in combinationally so the result is
    // available on the same edge the final iteration completes.
    assign product_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (en_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= done_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU with valid/ready handshake, registered result and flags.
// Single-cycle ops (ADD/SUB/AND/OR/NOR/SLL/SRL/SRA/reserved) load on the
// accepting edge; MUL runs WIDTH cycles in an iterative multiplier.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   in_valid / in_ready     - operation handshake
//   alu_opcode, s, t, imm   - opcode and operands; use_imm selects imm as src1
//   update_flags            - per-flag write mask {ov, neg, zero, carry}
//   out_valid / out_ready   - result handshake
//   ALU_result, flag_*      - registered result and flag state
//   busy                    - high while MUL iterates
module ex_alu_unit
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    input  logic [3:0]       update_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             flag_ov,
    output logic             flag_neg,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             busy
);

    localparam int unsigned SH_W = $clog2(WIDTH);
    localparam int unsigned MSB  = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       mask_q, mask_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             start_mul;
    logic             mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] src1;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic [3:0]       alu_mask;
    logic             alu_cy, alu_ov, alu_arith;

    assign src1      = use_imm ? WIDTH'($signed(imm)) : t;
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (alu_opcode == OP_MUL);

    ex_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_mul),
        .en_i     (state_q == ST_MUL),
        .a_i      (s),
        .b_i      (src1),
        .done_o   (mul_done),
        .product_o(product)
    );

    assign mul_lo    = product[WIDTH-1:0];
    assign mul_hi_nz = |product[2*WIDTH-1:WIDTH];
    assign mul_flags = {mul_hi_nz, mul_lo[MSB], (mul_lo == '0), mul_hi_nz};

    // Single-cycle datapath.
    always_comb begin
        sum       = '0;
        alu_res   = '0;
        alu_cy    = 1'b0;
        alu_ov    = 1'b0;
        alu_arith = 1'b0;
        alu_mask  = update_flags;
        case (alu_opcode)
            OP_ADD: begin
                sum       = {1'b0, s} + {1'b0, src1};
                alu_res   = sum[WIDTH-1:0];
                alu_cy    = sum[WIDTH];
                alu_ov    = (s[MSB] == src1[MSB]) && (alu_res[MSB] != s[MSB]);
                alu_arith = 1'b1;
            end
            OP_SUB: begin
                // carry is the carry-out of s + ~src1 + 1, i.e. 1 means no borrow
                sum       = {1'b0, s} + {1'b0, ~src1} + (WIDTH + 1)'(1);
                alu_res   = sum[WIDTH-1:0];
                alu_cy    = sum[WIDTH];
                alu_ov    = (s[MSB] != src1[MSB]) && (alu_res[MSB] != s[MSB]);
                alu_arith = 1'b1;
            end
            OP_AND: alu_res = s & src1;
            OP_OR:  alu_res = s | src1;
            OP_NOR: alu_res = ~(s | src1);
            OP_SLL: alu_res = s << src1[SH_W-1:0];
            OP_SRL: alu_res = s >> src1[SH_W-1:0];
            OP_SRA: alu_res = $unsigned($signed(s) >>> src1[SH_W-1:0]);
            OP_MUL: alu_res = '0;
            default: alu_mask = '0;  // reserved: result 0, flags untouched
        endcase
        alu_flags = {alu_ov,
                     alu_arith ? (alu_res[MSB] ^ alu_ov) : alu_res[MSB],
                     (alu_res == '0),
                     alu_cy};
    end

    // Control and register next-state.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            if (alu_opcode == OP_MUL) begin
                state_d = ST_MUL;
                mask_d  = update_flags;
            end else begin
                result_d    = alu_res;
                flags_d     = merge_flags(flags_q, alu_flags, alu_mask);
                out_valid_d = 1'b1;
            end
        end
        // accept needs IDLE, so it never coincides with mul_done
        if (mul_done) begin
            state_d     = ST_IDLE;
            result_d    = mul_lo;
            flags_d     = merge_flags(flags_q, mul_flags, mask_q);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ALU_result = result_q;
    assign flag_ov    = flags_q[FLAG_OV];
    assign flag_neg   = flags_q[FLAG_NEG];
    assign flag_zero  = flags_q[FLAG_ZERO];
    assign flag_carry = flags_q[FLAG_CARRY];
    assign busy       = (state_q == ST_MUL);

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit (WIDTH=32, IMM_W=17).
// The driver pushes a hand-computed {result, flags} when an op is accepted;
// the monitor pops and compares on every output transfer.
module tb_ex_alu_unit;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_opcode;
    logic [31:0] s;
    logic [31:0] t;
    logic [16:0] imm;
    logic        use_imm;
    logic [3:0]  update_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_result;
    logic        flag_ov, flag_neg, flag_zero, flag_carry;
    logic        busy;

    ex_alu_unit #(
        .WIDTH(32),
        .IMM_W(17)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_opcode  (alu_opcode),
        .s           (s),
        .t           (t),
        .imm         (imm),
        .use_imm     (use_imm),
        .update_flags(update_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_result  (ALU_result),
        .flag_ov     (flag_ov),
        .flag_neg    (flag_neg),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when both are high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got result 0x%0h expected no output",
                         ALU_result);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("result_%0d", mon_e.id), 64'(ALU_result), 64'(mon_e.res));
                check($sformatf("flags_%0d", mon_e.id),
                      64'({flag_ov, flag_neg, flag_zero, flag_carry}), 64'(mon_e.fl));
            end
        end
    end

    // Called in the posedge+1 phase; returns in the posedge+1 phase after accept.
    task automatic issue(input int id, input logic [3:0] op, input logic [31:0] sv,
                         input logic [31:0] tv, input logic [16:0] iv, input logic ui,
                         input logic [3:0] m, input logic [31:0] er, input logic [3:0] ef);
        int   n;
        exp_t e;
        alu_opcode   = op;
        s            = sv;
        t            = tv;
        imm          = iv;
        use_imm      = ui;
        update_flags = m;
        in_valid     = 1'b1;
        n            = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.id  = id;
                e.res = er;
                e.fl  = ef;
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout_%0d: got in_ready=0 for %0d cycles expected 1",
                         id, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        use_imm  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int rdy_hi;
        rst          = 1'b1;
        in_valid     = 1'b0;
        alu_opcode   = '0;
        s            = '0;
        t            = '0;
        imm          = '0;
        use_imm      = 1'b0;
        update_flags = '0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(ALU_result), 64'd0);
        check("rst_flags", 64'({flag_ov, flag_neg, flag_zero, flag_carry}), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Flags below are {ov, neg, zero, carry}.
        issue(1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 17'h0, 1'b0, 4'hF, 32'h8000_0000, 4'b1000);
        issue(2, OP_SUB, 32'h5, 32'h0, 17'h1FFFB, 1'b1, 4'hF, 32'hA, 4'b0000);
        issue(3, OP_SUB, 32'h3, 32'h3, 17'h0, 1'b0, 4'hF, 32'h0, 4'b0011);
        issue(4, OP_SRA, 32'h8000_0000, 32'h4, 17'h0, 1'b0, 4'h0, 32'hF800_0000, 4'b0011);
        issue(5, OP_MUL, 32'h1_0000, 32'h1_0000, 17'h0, 1'b0, 4'hF, 32'h0, 4'b1011);
        idle();
        // Inputs change during MUL; the captured operands must be used.
        s = 32'hDEAD_BEEF;
        t = 32'h1234_5678;
        n = 0;
        rdy_hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (in_ready) rdy_hi++;
        end
        check("mul_busy_cycles", 64'(n), 64'd32);
        check("mul_in_ready_high_cycles", 64'(rdy_hi), 64'd0);
        @(posedge clk);
        #1;

        issue(6,  OP_AND, 32'hF0F0, 32'hFF00, 17'h0, 1'b0, 4'hF, 32'hF000, 4'b0000);
        issue(7,  OP_OR,  32'hF0, 32'h0F, 17'h0, 1'b0, 4'hF, 32'hFF, 4'b0000);
        issue(8,  OP_NOR, 32'h0, 32'h0, 17'h0, 1'b0, 4'hF, 32'hFFFF_FFFF, 4'b0100);
        issue(9,  OP_SLL, 32'h1, 32'd31, 17'h0, 1'b0, 4'hF, 32'h8000_0000, 4'b0100);
        issue(10, OP_SRL, 32'h8000_0000, 32'd35, 17'h0, 1'b0, 4'hF, 32'h1000_0000, 4'b0000);
        issue(11, OP_ADD, 32'hFFFF_FFFF, 32'h1, 17'h0, 1'b0, 4'hF, 32'h0, 4'b0011);
        issue(12, OP_SUB, 32'h0, 32'h1, 17'h0, 1'b0, 4'b0100, 32'hFFFF_FFFF, 4'b0111);
        issue(13, 4'd9,   32'h5, 32'h5, 17'h0, 1'b0, 4'hF, 32'h0, 4'b0111);
        issue(14, OP_MUL, 32'h3, 32'h5, 17'h0, 1'b0, 4'hF, 32'hF, 4'b0000);
        issue(15, OP_SUB, 32'h8000_0000, 32'h1, 17'h0, 1'b0, 4'hF, 32'h7FFF_FFFF, 4'b1101);
        idle();
        drain();

        // Output held under backpressure, then drained with a new op on the same edge.
        out_ready = 1'b0;
        issue(16, OP_ADD, 32'h1, 32'h2, 17'h0, 1'b0, 4'hF, 32'h3, 4'b0000);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("hold_result_%0d", i), 64'(ALU_result), 64'd3);
            check($sformatf("hold_in_ready_%0d", i), 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(17, OP_ADD, 32'h4, 32'h5, 17'h0, 1'b0, 4'hF, 32'h9, 4'b0000);
        idle();
        check("same_edge_result", 64'(ALU_result), 64'd9);
        check("same_edge_valid", 64'(out_valid), 64'd1);
        drain();

        // Reset while a MUL is in flight discards it.
        issue(18, OP_ADD, 32'h7FFF_FFFF, 32'h1, 17'h0, 1'b0, 4'hF, 32'h8000_0000, 4'b1000);
        issue(99, OP_MUL, 32'h7, 32'h9, 17'h0, 1'b0, 4'hF, 32'd63, 4'b0000);
        idle();
        void'(sb.pop_back());  // the MUL above never completes
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midmul_rst_valid", 64'(out_valid), 64'd0);
        check("midmul_rst_busy", 64'(busy), 64'd0);
        check("midmul_rst_result", 64'(ALU_result), 64'd0);
        check("midmul_rst_flags", 64'({flag_ov, flag_neg, flag_zero, flag_carry}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rerelease_in_ready", 64'(in_ready), 64'd1);
        issue(19, OP_ADD, 32'h2, 32'h2, 17'h0, 1'b0, 4'hF, 32'h4, 4'b0000);
        idle();
        // Any leftover MUL completion would show up as an unexpected output.
        repeat (40) @(posedge clk);
        #1;
        drain();
        check("post_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_alu_unit.md
EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width (8 to 64).
REQ-002 Parameter IMM_W, default 17, sets the immediate width; it SHALL be at most WIDTH.
REQ-003 Derived localparam SH_W = $clog2(WIDTH) SHALL set the shift-amount width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operation presented.
REQ-007 in_ready  out  1  unit accepts operation this cycle.
REQ-008 alu_opcode  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9-15 reserved.
REQ-009 s  in  WIDTH  source operand 0.
REQ-010 t  in  WIDTH  source operand 1.
REQ-011 imm  in  IMM_W  immediate, sign-extended to WIDTH.
REQ-012 use_imm  in  1  src1 = sign-extended imm instead of t.
REQ-013 update_flags  in  4  write mask {ov, neg, zero, carry}.
REQ-014 out_valid  out  1  result held.
REQ-015 out_ready  in  1  consumer takes result.
REQ-016 ALU_result  out  WIDTH  registered result.
REQ-017 flag_ov, flag_neg, flag_zero, flag_carry  out  1 each  registered flag state.
REQ-018 busy  out  1  high while MUL iterates.

Function
REQ-019 An operation SHALL be accepted on a clock edge where in_valid && in_ready.
REQ-020 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready), giving full-throughput back-to-back single-cycle ops.
REQ-021 ADD/SUB/logic/shift ops SHALL register ALU_result and assert out_valid on the edge that accepts them (latency 1).
REQ-022 ADD SHALL be {carry,result} = s + src1; SUB SHALL be s + ~src1 + 1, with carry taken as the carry-out (carry=1 means no borrow).
REQ-023 ov: ADD when s[MSB]==src1[MSB] and result[MSB] differs; SUB when s[MSB]!=src1[MSB] and result[MSB]!=s[MSB].
REQ-024 neg SHALL be result[MSB]^ov for ADD/SUB and result[MSB] otherwise; zero SHALL be (result==0) for all ops.
REQ-025 Logic and shift ops SHALL produce carry=0 and ov=0.
REQ-026 Shifts SHALL use src1[SH_W-1:0] as the amount; SRA SHALL sign-fill.
REQ-027 MUL SHALL be unsigned shift-add: exactly WIDTH cycles in state MUL, then out_valid; result is the low WIDTH bits; carry=ov=1 iff the high WIDTH bits are nonzero.
REQ-028 FSM states: IDLE -> MUL (MUL accepted) -> IDLE (final iteration, result loaded); single-cycle ops stay in IDLE.
REQ-029 out_valid SHALL stay high, with ALU_result stable, until out_ready; it SHALL clear on out_ready unless a new result loads on the same edge.
REQ-030 Each flag SHALL update, on the edge the result loads, only when its update_flags bit (captured at accept) is 1; otherwise it holds.
REQ-031 Reserved opcodes SHALL complete in 1 cycle with result 0 and SHALL leave all flags unchanged.
REQ-032 Operands, opcode, and mask SHALL be captured at accept; input changes during MUL SHALL have no effect.

Reset
REQ-033 rst SHALL force state=IDLE, out_valid=0, busy=0, ALU_result=0, all flags=0, and the MUL counter to 0, including while a MUL is in flight (the MUL is discarded).
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 Shared package ex_pkg SHALL hold the opcode constants, the flag-mask bit indices, and the FSM state type.
REQ-036 The iterative multiplier SHALL be sub-module ex_mul_iter (start, operands, done, 2*WIDTH product), instantiated once.

Verification
REQ-037 WIDTH=32, ADD s=0x7FFFFFFF t=1 mask=1111 -> next cycle result 0x80000000, ov=1, neg=0, zero=0, carry=0.
REQ-038 SUB s=5 use_imm imm=0x1FFFB (-5) -> result 10, carry=0; then SUB s=3 t=3 -> result 0, zero=1, carry=1.
REQ-039 MUL s=0x10000 t=0x10000 -> busy for 32 cycles, in_ready=0; then result 0, carry=ov=1, zero=1.
REQ-040 SRA s=0x80000000 t=4 with mask=0000 after a zero=1 op -> result 0xF8000000, flags unchanged.
REQ-041 Hold out_ready=0 for 3 cycles after ADD -> out_valid and result stable and in_ready=0; then out_ready=1 with a new in_valid -> the new result loads on the same edge.
REQ-042 Assert rst at MUL cycle 10 -> all outputs 0 immediately; after release, ADD 2+2 -> 4 with no stale MUL result.
